// File: rtl/pb_conditioner.sv
// ---------------------------------------------------------------------------
// pb_conditioner
//   Front-end conditioner for raw pushbuttons. Each channel is synchronised to
//   Clk through two flops, debounced with a stable-time counter, and produces
//   a debounced level plus single-cycle press and release pulses.
//
// Parameters:
//   NUM_BTN         number of independent button channels
//   DEBOUNCE_CYCLES consecutive cycles the synchronised input must disagree
//                   with the debounced level before the level flips (>= 2)
//   CNT_W           counter width, 2**CNT_W > DEBOUNCE_CYCLES-1
//
// Ports:
//   Clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   pb_raw     in   asynchronous raw buttons, 1 = pressed
//   pb_level   out  debounced, registered level
//   pb_pulse   out  one-cycle pulse on each debounced 0->1 transition
//   pb_release out  one-cycle pulse on each debounced 1->0 transition
// ---------------------------------------------------------------------------
module pb_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] pb_raw,
  output logic [NUM_BTN-1:0] pb_level,
  output logic [NUM_BTN-1:0] pb_pulse,
  output logic [NUM_BTN-1:0] pb_release
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] pulse_q;
  logic [NUM_BTN-1:0] pulse_d;
  logic [NUM_BTN-1:0] release_q;
  logic [NUM_BTN-1:0] release_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // Debounce next-state: count disagreement cycles, flip the level once the
  // disagreement has lasted DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    level_d   = level_q;
    pulse_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == level_q[i]) begin
        // Any cycle of agreement restarts the stable-time count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i]   = sync2_q[i];
        cnt_d[i]     = '0;
        // Edge pulses are registered alongside the level, so they appear in
        // exactly the cycle the new level is first visible.
        pulse_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // State registers: synchroniser chain, debounced level, counters, pulses.
  always_ff @(posedge Clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= pb_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pb_level   = level_q;
  assign pb_pulse   = pulse_q;
  assign pb_release = release_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// ---------------------------------------------------------------------------
// tb_pb_conditioner
//   Directed self-checking bench for pb_conditioner with DEBOUNCE_CYCLES=4,
//   so a clean press or release shows up 6 edges after the raw change.
// ---------------------------------------------------------------------------
module tb_pb_conditioner;

  localparam int NB = 3;

  logic          Clk;
  logic          reset;
  logic [NB-1:0] pb_raw;
  logic [NB-1:0] pb_level;
  logic [NB-1:0] pb_pulse;
  logic [NB-1:0] pb_release;

  int checks;
  int errors;
  int npulse;

  pb_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .pb_raw    (pb_raw),
    .pb_level  (pb_level),
    .pb_pulse  (pb_pulse),
    .pb_release(pb_release)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    pb_raw = 3'b111;

    // 1: reset held with all buttons pressed -> everything stays 0
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("rst_outs", {23'd0, pb_level, pb_pulse, pb_release}, 32'd0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("rel_rst_level", {29'd0, pb_level}, (k >= 6) ? 32'd7 : 32'd0);
      check_eq("rel_rst_pulse", {29'd0, pb_pulse}, (k == 6) ? 32'd7 : 32'd0);
    end
    pb_raw = 3'b000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("all_release", {29'd0, pb_release}, (k == 6) ? 32'd7 : 32'd0);
    end
    check_eq("all_low", {29'd0, pb_level}, 32'd0);
    idle(3);

    // 2: 3-cycle glitch on channel 0 never gets through
    pb_raw = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("glitch_lvl", {31'd0, pb_level[0]}, 32'd0);
      check_eq("glitch_pls", {31'd0, pb_pulse[0]}, 32'd0);
    end
    pb_raw = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq("glitch_lvl", {31'd0, pb_level[0]}, 32'd0);
      check_eq("glitch_pls", {31'd0, pb_pulse[0]}, 32'd0);
    end

    // 3: channel 1 held 50 cycles -> one pulse at edge 6, then one release
    pb_raw = 3'b010;
    npulse = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (pb_pulse[1]) npulse++;
      check_eq("hold_pulse", {31'd0, pb_pulse[1]}, (k == 6) ? 32'd1 : 32'd0);
      check_eq("hold_level", {31'd0, pb_level[1]}, (k >= 6) ? 32'd1 : 32'd0);
    end
    check_eq("hold_npulse", npulse, 32'd1);
    pb_raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("hold_release", {31'd0, pb_release[1]}, (k == 6) ? 32'd1 : 32'd0);
      check_eq("hold_rel_lvl", {31'd0, pb_level[1]}, (k < 6) ? 32'd1 : 32'd0);
    end
    idle(3);

    // 4: channel 2 bounces 1,0,1,0 then settles high
    for (int k = 0; k < 4; k++) begin
      pb_raw = (k % 2 == 0) ? 3'b100 : 3'b000;
      tick();
      check_eq("bounce_pulse", {29'd0, pb_pulse}, 32'd0);
    end
    pb_raw = 3'b100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("bounce_pulse", {29'd0, pb_pulse}, (k == 6) ? 32'd4 : 32'd0);
    end
    pb_raw = 3'b000;
    idle(10);
    check_eq("bounce_idle", {29'd0, pb_level}, 32'd0);

    // 5: reset at edge 4 during a debounce -> partial count discarded
    pb_raw = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("midrst_pre", {29'd0, pb_pulse}, 32'd0);
    end
    reset = 1'b1;
    tick();
    check_eq("midrst_outs", {23'd0, pb_level, pb_pulse, pb_release}, 32'd0);
    reset = 1'b0;
    npulse = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (pb_pulse[0]) npulse++;
      check_eq("midrst_pulse", {31'd0, pb_pulse[0]}, (k == 6) ? 32'd1 : 32'd0);
    end
    check_eq("midrst_npulse", npulse, 32'd1);
    pb_raw = 3'b000;
    idle(10);

    // 6: channels 0 and 2 pressed together -> pulses in the same cycle
    pb_raw = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("simul_pulse", {29'd0, pb_pulse}, (k == 6) ? 32'd5 : 32'd0);
    end
    check_eq("simul_level", {29'd0, pb_level}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
